cube_color_tracker: RTL and testbench
=====================================

Name: cube_color_tracker

Overview:
- Upstream feeder of the map/colour renderer: owns the 28-bit per-cube top-colour state that the renderer consumes as e_color_state.
- On each completed Qbert jump (done_move rising edge), captures the one-hot cube position (position_qb) after a settle delay and updates that cube's colour bit according to the level mode.
- Maintains a lit-cube count and latches level completion until the game controller (NIOS) clears the board.

Parameters:
- N_CUBE, 28, number of cubes (bit width of position/colour vectors)
- CNT_W, 5, width of lit-cube count and cube index (must satisfy 2^CNT_W > N_CUBE)
- SETTLE_CYC, 2, clock cycles to wait after a done_move edge before sampling position_qb (covers monster_position register lag); legal range 1..15

Ports:
- CLK_33 in 1: system clock
- reset in 1: synchronous, active-high
- done_move in 1: jump-complete level from qbert layer; only its rising edge triggers
- position_qb in N_CUBE: one-hot cube-occupancy vector from the map/colour block
- e_toggle_mode in 1: 0 = set-only, 1 = toggle (NIOS); sampled in UPDATE
- e_color_clear in 1: board clear request (NIOS), single-cycle or level
- color_state out N_CUBE: per-cube top colour, drives e_color_state
- cubes_lit out CNT_W: popcount of color_state
- level_done out 1: latched when all N_CUBE cubes are lit
- landed_idx out CNT_W: index of the last validly landed cube
- landed_valid out 1: one-cycle pulse when landed_idx is updated
- bad_position out 1: one-cycle pulse when the captured position is zero or multi-hot

Behaviour:
- Reset: color_state=0, cubes_lit=0, level_done=0, landed_idx=0, landed_valid=0, bad_position=0, FSM=IDLE, done_move_q=0.
- Edge detect: `rise = done_move & ~done_move_q`, where done_move_q is registered every cycle. A held-high done_move never retriggers.
- FSM states: IDLE, WAIT, UPDATE, DONE.
- IDLE:
  - on rise, go to WAIT and load settle counter = SETTLE_CYC-1.
- WAIT:
  - decrement the counter;
  - when it reads 0, capture position_qb into pos_q and go to UPDATE.
  - Any rise seen during WAIT or UPDATE is dropped, not queued.
- UPDATE (single cycle):
  - pos_q exactly one-hot at index k:
    - set-only mode: color_state[k] <= 1;
    - toggle mode: color_state[k] <= ~color_state[k];
    - landed_idx <= k, landed_valid pulses.
  - pos_q zero or multi-hot: color_state unchanged, bad_position pulses, landed_idx unchanged.
  - Next state is IDLE.
- Timing, edge 0 being the one that samples the rise:
  - WAIT occupies edges 1..SETTLE_CYC;
  - position is captured on edge SETTLE_CYC;
  - color_state, landed_valid and bad_position change on edge SETTLE_CYC+1.
- cubes_lit: registered popcount of color_state, valid one cycle after color_state (edge SETTLE_CYC+2).
- level_done:
  - set on the edge after cubes_lit == N_CUBE (edge SETTLE_CYC+3);
  - FSM moves to DONE on that same edge.
  - In DONE, done_move edges are ignored and color_state is frozen, even in toggle mode.
- e_color_clear:
  - highest priority after reset;
  - on any edge where it is high: color_state=0, level_done=0, FSM=IDLE, settle counter cleared, pending update aborted, landed_valid/bad_position=0.
  - cubes_lit reaches 0 one cycle later.
  - A rise coincident with clear is dropped. landed_idx is kept.
- Mode change mid-operation: takes effect only at the next UPDATE.
- Toggle mode can decrement cubes_lit; level_done is only set, never cleared, except by clear or reset.
- Priority encoder: index k is the lowest set bit; it is used only when one-hot is confirmed via `(pos_q & (pos_q-1)) == 0 && pos_q != 0`.

Test Plan:
- Reset, then done_move rises with position_qb=28'h0000001, set mode, SETTLE_CYC=2 -> color_state=28'h0000001 and landed_idx=0 with landed_valid pulse on edge 3; cubes_lit=1 on edge 4.
- done_move held high for 20 cycles after one landing on bit 5 -> exactly one update; color_state=28'h0000020 and one landed_valid pulse.
- Toggle mode, two separate landings on bit 27 -> color_state goes 28'h8000000 then 0; cubes_lit 1 then 0.
- position_qb=0 at capture, then 28'h0000003 -> bad_position pulses twice, color_state unchanged, no landed_valid.
- Land on all 28 cubes in order in set mode -> level_done=1 on edge SETTLE_CYC+3 after the last rise; a further rise on any cube leaves color_state=28'hFFFFFFF; e_color_clear pulse -> color_state=0, level_done=0, cubes_lit=0 the next cycle.
- e_color_clear asserted during WAIT of a pending landing on bit 10 -> no update; color_state stays 0 and FSM returns to IDLE; reset asserted mid-WAIT gives the same result.

Source files
------------

// File: rtl/cube_color_tracker_if.sv
// Bus bundle between the game-side feeders and the cube colour tracker.
interface cube_color_tracker_if #(
  parameter int unsigned N_CUBE = 28,
  parameter int unsigned CNT_W  = 5
);
  logic              done_move;
  logic [N_CUBE-1:0] position_qb;
  logic              e_toggle_mode;
  logic              e_color_clear;
  logic [N_CUBE-1:0] color_state;
  logic [CNT_W-1:0]  cubes_lit;
  logic              level_done;
  logic [CNT_W-1:0]  landed_idx;
  logic              landed_valid;
  logic              bad_position;

  // Driver side: jump events, position and NIOS controls.
  modport master (
    output done_move, position_qb, e_toggle_mode, e_color_clear,
    input  color_state, cubes_lit, level_done, landed_idx, landed_valid, bad_position
  );

  // Tracker side.
  modport slave (
    input  done_move, position_qb, e_toggle_mode, e_color_clear,
    output color_state, cubes_lit, level_done, landed_idx, landed_valid, bad_position
  );
endinterface

// File: rtl/cube_color_tracker.sv
// Per-cube top-colour state: updates the landed cube after each Qbert jump,
// counts lit cubes and latches level completion until the board is cleared.
module cube_color_tracker #(
  parameter int unsigned N_CUBE     = 28,
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic                 CLK_33,
  input  logic                 reset,
  cube_color_tracker_if.slave  bus
);

  localparam int unsigned SET_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_UPDATE,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SET_W-1:0]  cnt_q, cnt_d;
  logic [N_CUBE-1:0] pos_q, pos_d;
  logic [N_CUBE-1:0] color_q, color_d;
  logic [CNT_W-1:0]  lit_q, lit_d;
  logic              level_done_q, level_done_d;
  logic [CNT_W-1:0]  landed_idx_q, landed_idx_d;
  logic              landed_valid_q, landed_valid_d;
  logic              bad_q, bad_d;
  logic              done_move_q, done_move_d;

  logic              rise;
  logic              pos_onehot;
  logic [CNT_W-1:0]  pos_idx;
  logic [CNT_W-1:0]  color_pop;
  logic              lit_full;

  assign rise       = bus.done_move & ~done_move_q;
  assign pos_onehot = (pos_q != '0) && ((pos_q & (pos_q - N_CUBE'(1))) == '0);
  // Count and vector must agree, so a stale count right after a clear cannot relatch level_done.
  assign lit_full   = (lit_q == CNT_W'(N_CUBE)) && (color_q == {N_CUBE{1'b1}});

  // Lowest set bit of the captured position (scan high to low so the lowest wins).
  always_comb begin
    pos_idx = '0;
    for (int i = int'(N_CUBE) - 1; i >= 0; i--) begin
      if (pos_q[i]) pos_idx = CNT_W'(i);
    end
  end

  // Popcount of the current colour vector.
  always_comb begin
    color_pop = '0;
    for (int i = 0; i < int'(N_CUBE); i++) begin
      color_pop = color_pop + CNT_W'(color_q[i]);
    end
  end

  // Next-state and output logic; clear overrides everything but reset.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pos_d          = pos_q;
    color_d        = color_q;
    lit_d          = color_pop;
    level_done_d   = level_done_q;
    landed_idx_d   = landed_idx_q;
    landed_valid_d = 1'b0;
    bad_d          = 1'b0;
    done_move_d    = bus.done_move;

    if (bus.e_color_clear) begin
      color_d      = '0;
      level_done_d = 1'b0;
      state_d      = ST_IDLE;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_WAIT;
            cnt_d   = SET_W'(SETTLE_CYC - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            pos_d   = bus.position_qb;
            state_d = ST_UPDATE;
          end else begin
            cnt_d = cnt_q - SET_W'(1);
          end
        end
        ST_UPDATE: begin
          state_d = ST_IDLE;
          if (pos_onehot) begin
            // pos_q is one-hot here, so it doubles as the bit mask.
            color_d        = bus.e_toggle_mode ? (color_q ^ pos_q) : (color_q | pos_q);
            landed_idx_d   = pos_idx;
            landed_valid_d = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (lit_full) begin
        level_done_d = 1'b1;
        state_d      = ST_DONE;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK_33) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pos_q          <= '0;
      color_q        <= '0;
      lit_q          <= '0;
      level_done_q   <= 1'b0;
      landed_idx_q   <= '0;
      landed_valid_q <= 1'b0;
      bad_q          <= 1'b0;
      done_move_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pos_q          <= pos_d;
      color_q        <= color_d;
      lit_q          <= lit_d;
      level_done_q   <= level_done_d;
      landed_idx_q   <= landed_idx_d;
      landed_valid_q <= landed_valid_d;
      bad_q          <= bad_d;
      done_move_q    <= done_move_d;
    end
  end

  assign bus.color_state  = color_q;
  assign bus.cubes_lit    = lit_q;
  assign bus.level_done   = level_done_q;
  assign bus.landed_idx   = landed_idx_q;
  assign bus.landed_valid = landed_valid_q;
  assign bus.bad_position = bad_q;

endmodule

// File: tb/tb_cube_color_tracker.sv
// Directed bench for cube_color_tracker with SETTLE_CYC = 2.
module tb_cube_color_tracker;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cube_color_tracker_if #(.N_CUBE(28), .CNT_W(5)) bus ();

  cube_color_tracker #(.N_CUBE(28), .CNT_W(5), .SETTLE_CYC(2)) dut (
    .CLK_33 (clk),
    .reset  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse clear for one cycle and let the count settle.
  task automatic do_clear();
    bus.e_color_clear = 1'b1;
    tick();
    bus.e_color_clear = 1'b0;
    tick();
  endtask

  // One jump onto pos; counts landed_valid / bad_position pulses over six edges.
  task automatic land(input logic [27:0] pos, output int nv, output int nb);
    nv = 0;
    nb = 0;
    bus.position_qb = pos;
    bus.done_move   = 1'b1;
    tick();
    bus.done_move = 1'b0;
    repeat (5) begin
      tick();
      nv += int'(bus.landed_valid);
      nb += int'(bus.bad_position);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (bus.color_state !== 28'h0 || bus.cubes_lit !== 5'd0 || bus.level_done !== 1'b0 ||
        bus.landed_idx !== 5'd0 || bus.landed_valid !== 1'b0 || bus.bad_position !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got color=%h lit=%0d done=%b idx=%0d v=%b b=%b exp all zero",
               bus.color_state, bus.cubes_lit, bus.level_done, bus.landed_idx,
               bus.landed_valid, bus.bad_position);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_landing();
    bus.position_qb = 28'h0000001;
    bus.done_move   = 1'b1;
    tick();  // edge 0
    bus.done_move = 1'b0;
    tick();  // edge 1
    tick();  // edge 2
    total++;
    if (bus.color_state !== 28'h0) begin
      bad++;
      $display("FAIL first_early got=%h exp=%h", bus.color_state, 28'h0);
    end
    tick();  // edge 3
    total++;
    if (bus.color_state !== 28'h0000001 || bus.landed_valid !== 1'b1 || bus.landed_idx !== 5'd0) begin
      bad++;
      $display("FAIL first_edge3 got color=%h v=%b idx=%0d exp color=1 v=1 idx=0",
               bus.color_state, bus.landed_valid, bus.landed_idx);
    end
    total++;
    if (bus.cubes_lit !== 5'd0) begin
      bad++;
      $display("FAIL first_lit_edge3 got=%0d exp=0", bus.cubes_lit);
    end
    tick();  // edge 4
    total++;
    if (bus.cubes_lit !== 5'd1 || bus.landed_valid !== 1'b0) begin
      bad++;
      $display("FAIL first_edge4 got lit=%0d v=%b exp lit=1 v=0", bus.cubes_lit, bus.landed_valid);
    end
  endtask

  task automatic test_held_high();
    int nv;
    do_clear();
    nv = 0;
    bus.position_qb = 28'h0000020;
    bus.done_move   = 1'b1;
    repeat (20) begin
      tick();
      nv += int'(bus.landed_valid);
    end
    bus.done_move = 1'b0;
    repeat (3) begin
      tick();
      nv += int'(bus.landed_valid);
    end
    total++;
    if (nv !== 1 || bus.color_state !== 28'h0000020 || bus.landed_idx !== 5'd5) begin
      bad++;
      $display("FAIL held_high got pulses=%0d color=%h idx=%0d exp pulses=1 color=0000020 idx=5",
               nv, bus.color_state, bus.landed_idx);
    end
  endtask

  task automatic test_toggle();
    int nv, nb;
    do_clear();
    bus.e_toggle_mode = 1'b1;
    land(28'h8000000, nv, nb);
    total++;
    if (bus.color_state !== 28'h8000000 || bus.cubes_lit !== 5'd1 || bus.landed_idx !== 5'd27) begin
      bad++;
      $display("FAIL toggle_on got color=%h lit=%0d idx=%0d exp color=8000000 lit=1 idx=27",
               bus.color_state, bus.cubes_lit, bus.landed_idx);
    end
    land(28'h8000000, nv, nb);
    total++;
    if (bus.color_state !== 28'h0 || bus.cubes_lit !== 5'd0 || nv !== 1) begin
      bad++;
      $display("FAIL toggle_off got color=%h lit=%0d v=%0d exp color=0 lit=0 v=1",
               bus.color_state, bus.cubes_lit, nv);
    end
    bus.e_toggle_mode = 1'b0;
  endtask

  task automatic test_bad_position();
    int nv0, nb0, nv1, nb1;
    do_clear();
    land(28'h0000000, nv0, nb0);
    land(28'h0000003, nv1, nb1);
    total++;
    if (nb0 + nb1 !== 2 || nv0 + nv1 !== 0) begin
      bad++;
      $display("FAIL bad_pulses got bad=%0d valid=%0d exp bad=2 valid=0", nb0 + nb1, nv0 + nv1);
    end
    total++;
    if (bus.color_state !== 28'h0 || bus.landed_idx !== 5'd27) begin
      bad++;
      $display("FAIL bad_state got color=%h idx=%0d exp color=0 idx=27",
               bus.color_state, bus.landed_idx);
    end
  endtask

  task automatic test_back_to_back();
    int nv;
    do_clear();
    nv = 0;
    bus.position_qb = 28'h0000002;
    bus.done_move   = 1'b1;
    tick();  // edge 0: accepted
    bus.done_move = 1'b0;
    tick();  // edge 1
    bus.done_move = 1'b1;
    tick();  // edge 2: rise during WAIT, dropped
    bus.done_move = 1'b0;
    repeat (8) begin
      tick();
      nv += int'(bus.landed_valid);
    end
    total++;
    if (nv !== 1 || bus.color_state !== 28'h0000002 || bus.landed_idx !== 5'd1) begin
      bad++;
      $display("FAIL back_to_back got pulses=%0d color=%h idx=%0d exp pulses=1 color=0000002 idx=1",
               nv, bus.color_state, bus.landed_idx);
    end
  endtask

  task automatic test_level_done();
    int nv, nb;
    logic [27:0] p;
    do_clear();
    for (int i = 0; i < 27; i++) begin
      p = 28'h1 << i;
      land(p, nv, nb);
    end
    total++;
    if (bus.color_state !== 28'h7FFFFFF || bus.cubes_lit !== 5'd27 || bus.level_done !== 1'b0) begin
      bad++;
      $display("FAIL level_27 got color=%h lit=%0d done=%b exp color=7FFFFFF lit=27 done=0",
               bus.color_state, bus.cubes_lit, bus.level_done);
    end
    bus.position_qb = 28'h8000000;
    bus.done_move   = 1'b1;
    tick();  // edge 0
    bus.done_move = 1'b0;
    repeat (3) tick();  // edge 3
    total++;
    if (bus.color_state !== 28'hFFFFFFF || bus.level_done !== 1'b0) begin
      bad++;
      $display("FAIL level_edge3 got color=%h done=%b exp color=FFFFFFF done=0",
               bus.color_state, bus.level_done);
    end
    tick();  // edge 4
    total++;
    if (bus.cubes_lit !== 5'd28 || bus.level_done !== 1'b0) begin
      bad++;
      $display("FAIL level_edge4 got lit=%0d done=%b exp lit=28 done=0", bus.cubes_lit, bus.level_done);
    end
    tick();  // edge 5
    total++;
    if (bus.level_done !== 1'b1) begin
      bad++;
      $display("FAIL level_edge5 got=%b exp=1", bus.level_done);
    end
    bus.e_toggle_mode = 1'b1;
    land(28'h0000008, nv, nb);
    bus.e_toggle_mode = 1'b0;
    total++;
    if (bus.color_state !== 28'hFFFFFFF || nv !== 0 || bus.level_done !== 1'b1) begin
      bad++;
      $display("FAIL level_frozen got color=%h v=%0d done=%b exp color=FFFFFFF v=0 done=1",
               bus.color_state, nv, bus.level_done);
    end
    bus.e_color_clear = 1'b1;
    tick();
    bus.e_color_clear = 1'b0;
    total++;
    if (bus.color_state !== 28'h0 || bus.level_done !== 1'b0) begin
      bad++;
      $display("FAIL level_clear got color=%h done=%b exp color=0 done=0", bus.color_state, bus.level_done);
    end
    tick();
    total++;
    if (bus.cubes_lit !== 5'd0 || bus.level_done !== 1'b0) begin
      bad++;
      $display("FAIL level_clear_next got lit=%0d done=%b exp lit=0 done=0", bus.cubes_lit, bus.level_done);
    end
  endtask

  task automatic test_abort_wait();
    int nv, nb;
    do_clear();
    nv = 0;
    bus.position_qb = 28'h0000400;
    bus.done_move   = 1'b1;
    tick();  // edge 0
    bus.done_move = 1'b0;
    tick();  // edge 1, in WAIT
    bus.e_color_clear = 1'b1;
    tick();  // edge 2: would have captured
    bus.e_color_clear = 1'b0;
    repeat (5) begin
      tick();
      nv += int'(bus.landed_valid);
    end
    total++;
    if (bus.color_state !== 28'h0 || nv !== 0) begin
      bad++;
      $display("FAIL clear_abort got color=%h v=%0d exp color=0 v=0", bus.color_state, nv);
    end
    land(28'h0000400, nv, nb);
    total++;
    if (bus.color_state !== 28'h0000400 || nv !== 1) begin
      bad++;
      $display("FAIL clear_then_land got color=%h v=%0d exp color=0000400 v=1", bus.color_state, nv);
    end
    do_clear();
    nv = 0;
    bus.done_move = 1'b1;
    tick();  // edge 0
    bus.done_move = 1'b0;
    rst = 1'b1;
    tick();  // reset during WAIT
    rst = 1'b0;
    repeat (5) begin
      tick();
      nv += int'(bus.landed_valid);
    end
    total++;
    if (bus.color_state !== 28'h0 || nv !== 0 || bus.landed_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_abort got color=%h v=%0d idx=%0d exp color=0 v=0 idx=0",
               bus.color_state, nv, bus.landed_idx);
    end
    land(28'h0000400, nv, nb);
    total++;
    if (bus.color_state !== 28'h0000400 || bus.landed_idx !== 5'd10) begin
      bad++;
      $display("FAIL reset_then_land got color=%h idx=%0d exp color=0000400 idx=10",
               bus.color_state, bus.landed_idx);
    end
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    rst               = 1'b1;
    bus.done_move     = 1'b0;
    bus.position_qb   = '0;
    bus.e_toggle_mode = 1'b0;
    bus.e_color_clear = 1'b0;
    test_reset();
    test_first_landing();
    test_held_high();
    test_toggle();
    test_bad_position();
    test_back_to_back();
    test_level_done();
    test_abort_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
